// File: rtl/pe_cnt_rpt.sv
// Run-level reporter: brackets a run by sys_start/sys_done edges, drains, then
// snapshots pe_cnt and the run length into one report per run over valid/ready.
module pe_cnt_rpt #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned CYC_W     = 40,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sys_start,
    input  logic             sys_done,
    input  logic [CNT_W-1:0] pe_cnt,
    output logic             rpt_vld,
    input  logic             rpt_rdy,
    output logic [CNT_W-1:0] rpt_pe_cnt,
    output logic [CYC_W-1:0] rpt_cyc,
    output logic             rpt_ovf,
    output logic             rpt_late,
    output logic [7:0]       run_id,
    output logic             busy
);

    localparam int unsigned DCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t             state;
    logic               start_q;
    logic               done_q;
    logic               start_e;
    logic               done_e;
    logic [CYC_W-1:0]   cyc;
    logic [CYC_W-1:0]   cyc_inc;
    logic               ovf;
    logic [DCNT_W-1:0]  dcnt;
    logic               pend;
    logic               late;

    // Edge qualifiers reset high so a level already asserted at reset release is not an edge.
    assign start_e = sys_start & ~start_q;
    assign done_e  = sys_done & ~done_q;
    assign cyc_inc = cyc + CYC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_q    <= 1'b1;
            done_q     <= 1'b1;
            cyc        <= '0;
            ovf        <= 1'b0;
            dcnt       <= '0;
            pend       <= 1'b0;
            late       <= 1'b0;
            rpt_vld    <= 1'b0;
            rpt_pe_cnt <= '0;
            rpt_cyc    <= '0;
            rpt_ovf    <= 1'b0;
            rpt_late   <= 1'b0;
            run_id     <= '0;
            busy       <= 1'b0;
        end else begin
            start_q <= sys_start;
            done_q  <= sys_done;
            case (state)
                IDLE: begin
                    if (start_e) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cyc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    if (start_e) begin
                        cyc <= '0;
                        ovf <= 1'b0;
                    end else begin
                        // Saturating run-length count; ovf latches once all-ones is reached.
                        if (cyc != {CYC_W{1'b1}}) begin
                            cyc <= cyc_inc;
                            if (cyc_inc == {CYC_W{1'b1}}) begin
                                ovf <= 1'b1;
                            end
                        end
                        if (done_e) begin
                            state <= DRAIN;
                            dcnt  <= DCNT_W'(DRAIN_CYC);
                        end
                    end
                end
                DRAIN: begin
                    if (start_e) begin
                        state <= RUN;
                        cyc   <= '0;
                        ovf   <= 1'b0;
                    end else begin
                        dcnt <= dcnt - DCNT_W'(1);
                        if (dcnt == DCNT_W'(1)) begin
                            rpt_pe_cnt <= pe_cnt;
                            rpt_cyc    <= cyc;
                            rpt_ovf    <= ovf;
                            rpt_late   <= late;
                            rpt_vld    <= 1'b1;
                            state      <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (rpt_vld && rpt_rdy) begin
                        rpt_vld <= 1'b0;
                        run_id  <= run_id + 8'd1;
                        // A start seen on the handshake edge itself is treated as pending too.
                        if (pend || start_e) begin
                            state <= RUN;
                            cyc   <= '0;
                            ovf   <= 1'b0;
                            late  <= 1'b1;
                            pend  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            late  <= 1'b0;
                        end
                    end else if (start_e) begin
                        pend <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
